spi_master: RTL

SPI_MASTER -- requirements
Module: spi_master

---
 rtl/spi_master.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/spi_master.sv
// -----------------------------------------------------------------------------
// spi_master -- single-byte SPI mode 0 master (CPOL=0, CPHA=0).
//
// Sends one byte MSB first per accepted request. SCLK idles low, MOSI only
// changes while SCLK is low, MISO is sampled on SCLK rising edges.
//
// Transfer timeline, measured in i_clk edges after the accepting edge (D = CLK_DIV):
//   0        SETUP entry: SS low, MOSI = bit 7
//   1+D      SHIFT entry, first SCLK rising edge
//   1+17D    HOLD entry (SCLK low, MOSI keeps bit 0)
//   1+18D    GAP entry: SS high, o_done (and o_rx_valid) pulse
//   1+19D    IDLE, o_ready high again
//
// Build option:
//   SPI_MASTER_RX_EN  when defined, MISO is captured into o_rx_data. When not
//                     defined, o_rx_data is 8'h00, o_rx_valid is 0 and
//                     i_spi_miso is ignored; all other timing is unchanged.
//
// Parameters:
//   CLK_DIV     SCLK half-period in i_clk cycles, legal range 2..255
//
// Ports:
//   i_clk       system clock, rising edge
//   i_rst_n     asynchronous active-low reset
//   i_data      byte to transmit, latched when i_valid && o_ready
//   i_valid     i_data valid
//   o_ready     idle and able to accept a byte
//   o_spi_clk   SCLK
//   o_spi_mosi  serial data out, MSB first, low whenever SS is high
//   i_spi_miso  serial data in
//   o_spi_ss    slave select, active low
//   o_done      one-cycle pulse at end of transfer
//   o_rx_data   byte captured from MISO
//   o_rx_valid  one-cycle pulse, o_rx_data updated
// -----------------------------------------------------------------------------
module spi_master #(
    parameter int CLK_DIV = 4
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [7:0] i_data,
    input  logic       i_valid,
    output logic       o_ready,
    output logic       o_spi_clk,
    output logic       o_spi_mosi,
    input  logic       i_spi_miso,
    output logic       o_spi_ss,
    output logic       o_done,
    output logic [7:0] o_rx_data,
    output logic       o_rx_valid
);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        GAP
    } state_t;

    // SETUP spans CLK_DIV+1 cycles (it includes the accept cycle), so its
    // terminal count is CLK_DIV; every other state spans CLK_DIV cycles.
    localparam logic [7:0] SETUP_LAST = 8'(CLK_DIV);
    localparam logic [7:0] DIV_LAST   = 8'(CLK_DIV - 1);

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;     // cycles spent in the current half-period
    logic [3:0] half_q, half_d;   // SCLK edges already issued in SHIFT
    logic       sclk_q, sclk_d;
    logic [7:0] tx_q, tx_d;       // outgoing byte, bit 7 drives MOSI
    logic       done_q, done_d;

    // NOTE: every variable assigned in this block gets a default first, so no
    // path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        half_d  = half_q;
        sclk_d  = sclk_q;
        tx_d    = tx_q;
        done_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (i_valid) begin
                    state_d = SETUP;
                    tx_d    = i_data;
                    cnt_d   = 8'd0;
                end
            end

            SETUP: begin
                if (cnt_q == SETUP_LAST) begin
                    state_d = SHIFT;
                    cnt_d   = 8'd0;
                    half_d  = 4'd0;
                    sclk_d  = 1'b1;   // first rising edge
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end

            SHIFT: begin
                if (cnt_q == DIV_LAST) begin
                    cnt_d = 8'd0;
                    if (half_q == 4'd15) begin
                        // The 16th half-period has elapsed; SCLK is already low.
                        state_d = HOLD;
                    end else begin
                        sclk_d = ~sclk_q;
                        half_d = half_q + 4'd1;
                        // Shift on the first seven falling edges only, so bit 0
                        // stays on MOSI after the last falling edge.
                        if (sclk_q && (half_q != 4'd14)) begin
                            tx_d = {tx_q[6:0], 1'b0};
                        end
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end

            HOLD: begin
                if (cnt_q == DIV_LAST) begin
                    state_d = GAP;
                    cnt_d   = 8'd0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end

            GAP: begin
                if (cnt_q == DIV_LAST) begin
                    state_d = IDLE;
                    cnt_d   = 8'd0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end

            default: begin
                state_d = IDLE;
                cnt_d   = 8'd0;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
            half_q  <= 4'd0;
            sclk_q  <= 1'b0;
            tx_q    <= 8'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            half_q  <= half_d;
            sclk_q  <= sclk_d;
            tx_q    <= tx_d;
            done_q  <= done_d;
        end
    end

    // SS and MOSI decode straight from the state register, so an asynchronous
    // reset releases the bus in the same cycle.
    assign o_ready    = (state_q == IDLE);
    assign o_spi_ss   = (state_q == IDLE) || (state_q == GAP);
    assign o_spi_mosi = !o_spi_ss && tx_q[7];
    assign o_spi_clk  = sclk_q;
    assign o_done     = done_q;

`ifdef SPI_MASTER_RX_EN
    logic [7:0] rx_shift_q;
    logic [7:0] rx_data_q;
    logic       rx_valid_q;
    logic       sclk_rise;

    // SCLK is registered, so a rising edge becomes visible on this i_clk edge;
    // MISO is sampled with the same edge.
    assign sclk_rise = sclk_d && !sclk_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rx_shift_q <= 8'd0;
            rx_data_q  <= 8'd0;
            rx_valid_q <= 1'b0;
        end else begin
            if (sclk_rise) begin
                rx_shift_q <= {rx_shift_q[6:0], i_spi_miso};
            end
            if (done_d) begin
                rx_data_q <= rx_shift_q;
            end
            rx_valid_q <= done_d;
        end
    end

    assign o_rx_data  = rx_data_q;
    assign o_rx_valid = rx_valid_q;
`else
    logic unused_miso;

    assign unused_miso = i_spi_miso;
    assign o_rx_data   = 8'h00;
    assign o_rx_valid  = 1'b0;
`endif

endmodule
